result_stream_buffer: RTL and testbench

Registered, elastic buffer directly downstream of the 20-bit combinational datapath stage. It captures that stage's result word under a valid/ready handshake and holds it in a small show-ahead FIFO. It keeps a saturating count of accepted words. It can optionally fold every accepted word into a running signature for on-chip self-check. It decouples the combinational stage from a back-pressuring consumer.

---
 rtl/result_stream_buffer.sv | 130 +++++++++++++
 tb/tb_result_stream_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_buffer.sv
// rtl/result_stream_buffer.sv - show-ahead elastic buffer for the 20-bit result stream
//
// Purpose:
//   Captures the upstream combinational stage's result word under a
//   valid/ready handshake. Holds it in a DEPTH-entry show-ahead FIFO.
//   Keeps a saturating count of accepted words. When RESULT_SIG_EN is
//   defined, it also folds every accepted word into a running signature.
//
// Optional feature macro: RESULT_SIG_EN
//   defined     : signature <= rotl1(signature) ^ input_data on each push
//   not defined : no signature register; signature output tied to 0
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous flush of FIFO, counter and signature
//   in_valid     in   upstream word present
//   in_ready     out  buffer can accept a word (registered state only)
//   input_data   in   DATA_W word from the upstream stage
//   out_valid    out  head word available
//   out_ready    in   consumer accepts the head word
//   output_data  out  head word (0 when empty)
//   level        out  occupancy 0..DEPTH
//   accepted_cnt out  saturating count of accepted words
//   signature    out  running signature (0 when feature disabled)

module result_stream_buffer #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        input_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        output_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         accepted_cnt,
   output logic [DATA_W-1:0]        signature
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_push;
   logic              w_pop;

   // Both flags depend only on the registered level. A pop in a full cycle
   // therefore never opens the input in that same cycle.
   assign w_in_ready  = (r_level != LVL_W'(DEPTH));
   assign w_out_valid = (r_level != '0);
   assign w_push      = in_valid  && w_in_ready;
   assign w_pop       = w_out_valid && out_ready;

   assign in_ready     = w_in_ready;
   assign out_valid    = w_out_valid;
   assign level        = r_level;
   assign accepted_cnt = r_cnt;

   // Show-ahead read. Zero is forced when empty, so stale storage never leaks out.
   assign output_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;

   // Storage needs no reset. Its contents are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (w_push && !clr) begin
         r_mem[r_wr_ptr] <= input_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_cnt    <= '0;
      end else if (clr) begin
         // Flush wins over any push/pop presented in the same cycle.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (r_cnt != {CNT_W{1'b1}}) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

`ifdef RESULT_SIG_EN
   logic [DATA_W-1:0] r_sig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (clr) begin
         r_sig <= '0;
      end else if (w_push) begin
         r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ input_data;
      end
   end

   assign signature = r_sig;
`else
   assign signature = '0;
`endif

endmodule

// File: tb/tb_result_stream_buffer.sv
// tb/tb_result_stream_buffer.sv - self-checking bench for result_stream_buffer

module tb_result_stream_buffer;

   localparam int DW    = 20;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

`ifdef RESULT_SIG_EN
   localparam bit SIG_EN = 1'b1;
`else
   localparam bit SIG_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] input_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] output_data;
   logic [2:0]    level;
   logic [CW-1:0] accepted_cnt;
   logic [DW-1:0] signature;

   result_stream_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .input_data   (input_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .output_data  (output_data),
      .level        (level),
      .accepted_cnt (accepted_cnt),
      .signature    (signature)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the FIFO contents as a queue, plus a counter and signature.
   logic [DW-1:0] m_q[$];
   int            m_cnt;
   logic [DW-1:0] m_sig;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cnt = 0;
      m_sig = '0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, m_q.size() != DEPTH});
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      chk({tag, ".data"},      {12'd0, output_data}, (m_q.size() != 0) ? {12'd0, m_q[0]} : 32'd0);
      chk({tag, ".level"},     {29'd0, level},     m_q.size());
      chk({tag, ".cnt"},       {16'd0, accepted_cnt}, m_cnt);
      chk({tag, ".sig"},       {12'd0, signature}, SIG_EN ? {12'd0, m_sig} : 32'd0);
   endtask

   // Drive one cycle of inputs, advance one clock edge, update the model, then compare.
   task automatic step(input bit c, input bit iv, input logic [DW-1:0] d, input bit ordy,
                       input string tag);
      bit push, pop;
      clr        = c;
      in_valid   = iv;
      input_data = d;
      out_ready  = ordy;
      push = iv && (m_q.size() != DEPTH);
      pop  = ordy && (m_q.size() != 0);
      @(posedge clk);
      #1;
      if (c) begin
         model_reset();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(d);
            if (m_cnt < 65535) m_cnt++;
            m_sig = {m_sig[DW-2:0], m_sig[DW-1]} ^ d;
         end
      end
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr = 0; in_valid = 0; input_data = '0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit            c;
      bit            iv;
      logic [DW-1:0] d;
      bit            ordy;
      bit            e_ov;
      logic [DW-1:0] e_d;
      logic [2:0]    e_lvl;
      bit            e_ir;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{0, 1, 20'h12345, 0, 1, 20'h12345, 3'd1, 1, 16'd1};
      vecs[1]  = '{0, 0, 20'h00000, 1, 0, 20'h00000, 3'd0, 1, 16'd1};
      vecs[2]  = '{0, 1, 20'h00001, 0, 1, 20'h00001, 3'd1, 1, 16'd2};
      vecs[3]  = '{0, 1, 20'h00002, 0, 1, 20'h00001, 3'd2, 1, 16'd3};
      vecs[4]  = '{0, 1, 20'h00003, 0, 1, 20'h00001, 3'd3, 1, 16'd4};
      vecs[5]  = '{0, 1, 20'h00004, 0, 1, 20'h00001, 3'd4, 0, 16'd5};
      vecs[6]  = '{0, 1, 20'hFFFFF, 0, 1, 20'h00001, 3'd4, 0, 16'd5};
      // Full with a pop: the push is still refused this cycle.
      vecs[7]  = '{0, 1, 20'hFFFFF, 1, 1, 20'h00002, 3'd3, 1, 16'd5};
      vecs[8]  = '{0, 1, 20'hFFFFF, 1, 1, 20'h00003, 3'd3, 1, 16'd6};
      vecs[9]  = '{0, 0, 20'h00000, 1, 1, 20'h00004, 3'd2, 1, 16'd6};
      vecs[10] = '{0, 0, 20'h00000, 1, 1, 20'hFFFFF, 3'd1, 1, 16'd6};
      vecs[11] = '{0, 0, 20'h00000, 1, 0, 20'h00000, 3'd0, 1, 16'd6};

      do_reset();
      #1;
      chk("reset.in_ready",  {31'd0, in_ready},  32'd1);
      chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset.data",      {12'd0, output_data}, 32'd0);
      chk("reset.level",     {29'd0, level},     32'd0);
      chk("reset.cnt",       {16'd0, accepted_cnt}, 32'd0);
      chk("reset.sig",       {12'd0, signature}, 32'd0);

      // Table-driven directed sequence
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].c, vecs[i].iv, vecs[i].d, vecs[i].ordy, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tbl_ov", i),  {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         chk($sformatf("vec%0d.tbl_d", i),   {12'd0, output_data}, {12'd0, vecs[i].e_d});
         chk($sformatf("vec%0d.tbl_lvl", i), {29'd0, level}, {29'd0, vecs[i].e_lvl});
         chk($sformatf("vec%0d.tbl_ir", i),  {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
         chk($sformatf("vec%0d.tbl_cnt", i), {16'd0, accepted_cnt}, {16'd0, vecs[i].e_cnt});
      end

      // Steady stream from level 1 across pointer wrap
      step(0, 1, 20'h00100, 0, "stream.pre");
      begin
         logic [CW-1:0] cnt0;
         cnt0 = accepted_cnt;
         for (int i = 1; i <= 10; i++) begin
            step(0, 1, 20'h00100 + 20'(i), 1, $sformatf("stream%0d", i));
            chk($sformatf("stream%0d.lvl1", i), {29'd0, level}, 32'd1);
            chk($sformatf("stream%0d.head", i), {12'd0, output_data}, 32'h100 + i);
         end
         chk("stream.cnt_delta", {16'd0, accepted_cnt - cnt0}, 32'd10);
      end

      // Signature from a fresh reset
      do_reset();
      step(0, 1, 20'h00001, 0, "sig1");
      chk("sig1.abs", {12'd0, signature}, SIG_EN ? 32'h00001 : 32'd0);
      step(0, 1, 20'h80000, 0, "sig2");
      chk("sig2.abs", {12'd0, signature}, SIG_EN ? 32'h80002 : 32'd0);

      // Clear with simultaneous push and pop at level 3
      step(0, 1, 20'h0000A, 0, "clrfill");
      chk("clrfill.lvl3", {29'd0, level}, 32'd3);
      step(1, 1, 20'h0000B, 1, "clr");
      chk("clr.lvl",  {29'd0, level},     32'd0);
      chk("clr.ov",   {31'd0, out_valid}, 32'd0);
      chk("clr.cnt",  {16'd0, accepted_cnt}, 32'd0);
      chk("clr.sig",  {12'd0, signature}, 32'd0);

      // Async reset mid-cycle during a burst
      step(0, 1, 20'h00055, 0, "burst1");
      step(0, 1, 20'h00066, 0, "burst2");
      in_valid = 1; input_data = 20'h00077; out_ready = 1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst.data",      {12'd0, output_data}, 32'd0);
      chk("arst.level",     {29'd0, level},     32'd0);
      chk("arst.cnt",       {16'd0, accepted_cnt}, 32'd0);
      chk("arst.sig",       {12'd0, signature}, 32'd0);
      in_valid = 0; out_ready = 0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), $urandom_range(0, 1), DW'($urandom),
              ($urandom_range(0, 2) != 0), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
